seq_div32: RTL and testbench
============================

SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/result width; only 32 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when FSM in IDLE or DONE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 x  input  WIDTH  dividend, sampled with start.
REQ-007 y  input  WIDTH  divisor, sampled with start.
REQ-008 busy  output  1  high while iterating (CALC state).
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  WIDTH  quotient or remainder per op; held from done until next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, CALC, DONE; busy=1 only in CALC, done=1 only in DONE.
REQ-012 IDLE/DONE with start=1: y==0 or (signed op, x==0x80000000, y==0xFFFFFFFF) -> DONE next cycle (special path); otherwise -> CALC with count=0.
REQ-013 start during CALC SHALL be ignored; op/x/y changes after acceptance SHALL not affect the result.
REQ-014 On acceptance: signed ops latch |x|, |y|, quotient sign = x[31]^y[31], remainder sign = x[31]; unsigned ops latch x, y unchanged with both signs 0.
REQ-015 CALC: restoring division, one quotient bit per cycle: shift {rem,quot} left 1, trial = rem - divisor at WIDTH+1 bits; borrow clear -> rem=trial, quot bit=1; else quot bit=0.
REQ-016 CALC SHALL last exactly WIDTH cycles (count 0..WIDTH-1), then -> DONE; done asserted WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
REQ-017 DONE: result = signed-corrected quotient (DIV/DIVU) or remainder (REM/REMU), two's-complement negation when sign bit set; DONE -> IDLE next cycle unless start accepted.
REQ-018 Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = x, done one edge after acceptance.
REQ-019 Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0, done one edge after acceptance.
REQ-020 Quotient truncates toward zero; nonzero remainder SHALL have the dividend's sign.
REQ-021 start in DONE SHALL be accepted as in IDLE (back-to-back ops, no idle gap).

Reset
REQ-022 rst=1 at any edge SHALL force IDLE, busy=0, done=0, result=0, count=0, regardless of state; in-flight operation discarded with no done.
REQ-023 rst SHALL dominate start in the same cycle.

Structure
REQ-024 Shared package SHALL hold op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), the FSM state enum, and constant INT_MIN=0x80000000.
REQ-025 One sub-module div_step (combinational WIDTH+1-bit trial subtract, outputs difference and borrow) SHALL be instantiated once; FSM, counter, sign fix-up stay in seq_div32.

Verification
REQ-026 DIVU x=100 y=7 -> done 33 edges after start, result=14; REMU same -> result=2; busy high exactly 32 cycles.
REQ-027 DIV x=0xFFFFFFF9 (-7) y=2 -> result=0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); REM x=7 y=0xFFFFFFFE -> 1.
REQ-028 DIVU x=5 y=0 -> result=0xFFFFFFFF, REMU -> 5, both with done one edge after start, busy never high.
REQ-029 DIV x=0x80000000 y=0xFFFFFFFF -> 0x80000000; REM same -> 0; done one edge after start.
REQ-030 Start DIVU 100/7, assert start with x=1 y=1 at CALC cycle 5 -> ignored, result=14; assert rst at CALC cycle 10 -> next cycle busy=0, done=0, result=0, no done pulse follows.
REQ-031 Start asserted in the DONE cycle with DIVU 0xFFFFFFFF/0x10 -> accepted, second done 33 edges later with result=0x0FFFFFFF.

Source files
------------

// File: rtl/seq_div32_pkg.sv
// Shared definitions for the sequential RV32M-style divider: op encodings,
// FSM states and the signed-overflow dividend.
package seq_div32_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_div32_div_step.sv
// One restoring-division trial subtract: partial remainder minus divisor at
// WIDTH+1 bits, returning the low WIDTH bits of the difference and the borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // The top bit of the difference is only meaningful when borrow is set,
    // and then the difference is discarded, so only the low bits leave here.
    assign diff   = a[WIDTH-1:0] - b[WIDTH-1:0];
    assign borrow = (a < b);

endmodule

// File: rtl/seq_div32.sv
// Iterative 32-bit divider: one quotient bit per cycle, RV32M DIV/DIVU/REM/REMU
// semantics including divide-by-zero and signed-overflow special cases.
module seq_div32
    import seq_div32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             qsign_reg;
    logic             rsign_reg;
    logic             is_rem_reg;

    logic             signed_op;
    logic [WIDTH-1:0] abs_x;
    logic [WIDTH-1:0] abs_y;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign signed_op = ~op[0];
    assign abs_x     = (signed_op && x[WIDTH-1]) ? -x : x;
    assign abs_y     = (signed_op && y[WIDTH-1]) ? -y : y;
    assign div_zero  = (y == '0);
    assign overflow  = signed_op && (x == MIN_VAL) && (y == '1);

    // The dividend is held in quot_reg and shifted out MSB-first into the remainder.
    assign partial = {rem_reg, quot_reg[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .a      (partial),
        .b      ({1'b0, divisor_reg}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_step  = borrow ? partial[WIDTH-1:0] : trial;
    assign quot_step = {quot_reg[WIDTH-2:0], ~borrow};
    assign quot_fix  = qsign_reg ? -quot_step : quot_step;
    assign rem_fix   = rsign_reg ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            is_rem_reg  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
        end else begin
            case (state_reg)
                ST_CALC: begin
                    rem_reg   <= rem_step;
                    quot_reg  <= quot_step;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH-1)) begin
                        result    <= is_rem_reg ? rem_fix : quot_fix;
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (div_zero) begin
                            result    <= op[1] ? x : '1;
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else if (overflow) begin
                            result    <= op[1] ? '0 : MIN_VAL;
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            rem_reg     <= '0;
                            quot_reg    <= abs_x;
                            divisor_reg <= abs_y;
                            qsign_reg   <= signed_op & (x[WIDTH-1] ^ y[WIDTH-1]);
                            rsign_reg   <= signed_op & x[WIDTH-1];
                            is_rem_reg  <= op[1];
                            count_reg   <= '0;
                            state_reg   <= ST_CALC;
                            busy        <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div32.sv
// Directed-vector bench for seq_div32: normal, signed, special-path, ignored
// start, mid-flight reset and back-to-back operations.
module tb_seq_div32;
    import seq_div32_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    seq_div32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h, required %h", tag, obs, exp);
    endtask

    // Drives start from the current point; counts edges until done and busy cycles.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int edges, output int busy_cnt);
        bit got;
        start = 1'b1; op = o; x = a; y = b;
        edges = 0; busy_cnt = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                start = 1'b0;
                op = 2'($urandom); x = $urandom; y = $urandom;
            end
            if (busy) busy_cnt++;
            if (done) got = 1;
        end
        res = result;
        $display("op=%0d x=%h y=%h result=%h edges=%0d busy=%0d", o, a, b, res, edges, busy_cnt);
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          exp_edges;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        int          edges;
        int          bcnt;
        bit          got;
        int          done_seen;

        rst = 1'b1; start = 1'b0; op = OP_DIVU; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{"div_min_2",    OP_DIV,  INT_MIN,        32'd2,          32'hC000_0000,  33});
        vecs.push_back('{"remu_big_16",  OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33});
        vecs.push_back('{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{"div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"div_ovf",      OP_DIV,  INT_MIN,        32'hFFFF_FFFF,  INT_MIN,        1});
        vecs.push_back('{"rem_ovf",      OP_REM,  INT_MIN,        32'hFFFF_FFFF,  32'd0,          1});

        foreach (vecs[i]) begin
            @(negedge clk);
            do_op(vecs[i].o, vecs[i].a, vecs[i].b, res, edges, bcnt);
            check({vecs[i].tag, "_result"}, res, vecs[i].exp);
            check({vecs[i].tag, "_latency"}, 32'(edges), 32'(vecs[i].exp_edges));
            check({vecs[i].tag, "_busy_cycles"}, 32'(bcnt), (vecs[i].exp_edges == 1) ? 32'd0 : 32'd32);
            @(posedge clk); #1;
            check({vecs[i].tag, "_done_pulse"}, 32'(done), 32'd0);
            check({vecs[i].tag, "_held"}, result, vecs[i].exp);
        end

        // start during CALC must be ignored
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; x = 32'd100; y = 32'd7;
        edges = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            edges++;
            start = 1'b0;
            if (edges == 6) begin start = 1'b1; x = 32'd1; y = 32'd1; end
            if (done) got = 1;
        end
        $display("op=%0d x=%h y=%h result=%h edges=%0d (start in CALC)", OP_DIVU, 32'd100, 32'd7, result, edges);
        check("ignore_start_result", result, 32'd14);
        check("ignore_start_latency", 32'(edges), 32'd33);

        // reset mid-flight discards the operation
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; x = 32'd100; y = 32'd7;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (e == 11) rst = 1'b1;
        end
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        $display("op=%0d x=%h y=%h reset in CALC, done pulses after=%0d", OP_DIVU, 32'd100, 32'd7, done_seen);
        check("midrst_no_done", 32'(done_seen), 32'd0);

        // back-to-back: second start issued in the DONE cycle
        @(negedge clk);
        do_op(OP_DIVU, 32'd100, 32'd7, res, edges, bcnt);
        check("b2b_first_result", res, 32'd14);
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, res, edges, bcnt);
        check("b2b_second_result", res, 32'h0FFF_FFFF);
        check("b2b_second_latency", 32'(edges), 32'd33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
